regfile_dump_seq: RTL and testbench

Hardware sequencer that dumps the CPU register file at the end of a pipeline test run. It takes over the instruction stream with forced I-type instructions whose rs field selects one register. It samples the pipeline's busA probe after a programmable settle time and streams {index, value} beats out on a valid/ready channel. It is the parametrised, range-selectable, back-pressure-aware generalisation of the fixed 32-register dump loop, and sits between the instruction-memory override mux and the pipeline.

---
 rtl/regfile_dump_seq.sv | 187 ++++++++++++++++++
 tb/tb_regfile_dump_seq.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_seq.sv
// regfile_dump_seq: takes over the instruction stream with forced I-type
// instructions, one per register, samples the busA probe after a settle
// delay and streams {index, value} beats on a valid/ready channel.
// Optional feature macro: DUMP_CHECKSUM_EN appends an XOR checksum beat.
module regfile_dump_seq #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned IDX_W         = 5,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [5:0]  OPCODE        = 6'b001000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [IDX_W-1:0]  first_reg,
    input  logic [IDX_W-1:0]  last_reg,
    input  logic [DATA_W-1:0] busA_probe,
    output logic              override_inst,
    output logic [31:0]       force_inst,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [IDX_W-1:0]  dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned      CNT_W    = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD, CHK} state_e;
`else
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;
`endif

    state_e            state_q;
    logic [IDX_W-1:0]  cur_q;
    logic [IDX_W-1:0]  last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovr_q;
    logic [31:0]       inst_q;
    logic              valid_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] data_q;
    logic              dlast_q;
    logic              busy_q;
    logic              done_q;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q;
`endif

    logic [IDX_W-1:0]  cur_d;
    logic              hs_d;

    // Forced I-type instruction: rs field carries the register index (5 bits).
    function automatic logic [31:0] mk_inst(input logic [IDX_W-1:0] idx);
        logic [4:0] rs;
        rs = 5'(idx);
        return {OPCODE, rs, 5'b0, 16'b0};
    endfunction

    // Next register index and handshake qualifier.
    always_comb begin
        cur_d = cur_q + IDX_W'(1);
        hs_d  = valid_q & dump_ready;
    end

    // Sequencer FSM; every output is a register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            dlast_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE && abort) begin
                state_q <= IDLE;
                ovr_q   <= 1'b0;
                valid_q <= 1'b0;
                dlast_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            if (first_reg <= last_reg) begin
                                state_q <= SETTLE;
                                cur_q   <= first_reg;
                                last_q  <= last_reg;
                                cnt_q   <= CNT_LOAD;
                                ovr_q   <= 1'b1;
                                inst_q  <= mk_inst(first_reg);
                                busy_q  <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                                acc_q   <= '0;
`endif
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    SETTLE: begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= HOLD;
                            data_q  <= busA_probe;
                            idx_q   <= cur_q;
                            valid_q <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                            dlast_q <= 1'b0;
                            acc_q   <= acc_q ^ busA_probe;
`else
                            dlast_q <= (cur_q == last_q);
`endif
                        end
                    end
                    HOLD: begin
                        if (hs_d) begin
                            if (cur_q != last_q) begin
                                state_q <= SETTLE;
                                cur_q   <= cur_d;
                                inst_q  <= mk_inst(cur_d);
                                valid_q <= 1'b0;
                                cnt_q   <= CNT_LOAD;
                            end else begin
`ifdef DUMP_CHECKSUM_EN
                                // Beat stays valid; payload becomes the checksum.
                                state_q <= CHK;
                                ovr_q   <= 1'b0;
                                data_q  <= acc_q;
                                idx_q   <= '0;
                                dlast_q <= 1'b1;
`else
                                state_q <= IDLE;
                                ovr_q   <= 1'b0;
                                valid_q <= 1'b0;
                                dlast_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef DUMP_CHECKSUM_EN
                    CHK: begin
                        if (hs_d) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            dlast_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
`endif
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Output port mapping.
    always_comb begin
        override_inst = ovr_q;
        force_inst    = inst_q;
        dump_valid    = valid_q;
        dump_idx      = idx_q;
        dump_data     = data_q;
        dump_last     = dlast_q;
        busy          = busy_q;
        done          = done_q;
    end

endmodule

// File: tb/tb_regfile_dump_seq.sv
// Bench for regfile_dump_seq: instance A (SETTLE_CYCLES=1, combinational
// probe) and instance B (SETTLE_CYCLES=3, probe lagging the forced
// instruction by two edges). Expected beats are queued per test and popped
// on each observed handshake. Define DUMP_CHECKSUM_EN for the checksum build.
module tb_regfile_dump_seq;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } beat_t;

`ifdef DUMP_CHECKSUM_EN
    localparam int CHK_EXTRA = 1;
`else
    localparam int CHK_EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // instance A signals
    logic        start_a = 0, abort_a = 0, ready_a = 1;
    logic [4:0]  first_a = '0, last_a = '0;
    logic [31:0] busa_a;
    logic        ovr_a, valid_a, dlast_a, busy_a, done_a;
    logic [31:0] finst_a, data_a;
    logic [4:0]  idx_a;

    // instance B signals
    logic        start_b = 0, abort_b = 0, ready_b = 1;
    logic [4:0]  first_b = '0, last_b = '0;
    logic [31:0] busa_b, st1_b, st2_b;
    logic        ovr_b, valid_b, dlast_b, busy_b, done_b;
    logic [31:0] finst_b, data_b;
    logic [4:0]  idx_b;

    int unsigned rf_mode = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    beat_t       exp_q[$];
    beat_t       got, exp;
    logic [31:0] last_beat_data;

    regfile_dump_seq #(.DATA_W(32), .IDX_W(5), .SETTLE_CYCLES(1), .OPCODE(6'b001000)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .first_reg(first_a), .last_reg(last_a), .busA_probe(busa_a),
        .override_inst(ovr_a), .force_inst(finst_a), .dump_valid(valid_a),
        .dump_ready(ready_a), .dump_idx(idx_a), .dump_data(data_a),
        .dump_last(dlast_a), .busy(busy_a), .done(done_a)
    );

    regfile_dump_seq #(.DATA_W(32), .IDX_W(5), .SETTLE_CYCLES(3), .OPCODE(6'b001000)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .first_reg(first_b), .last_reg(last_b), .busA_probe(busa_b),
        .override_inst(ovr_b), .force_inst(finst_b), .dump_valid(valid_b),
        .dump_ready(ready_b), .dump_idx(idx_b), .dump_data(data_b),
        .dump_last(dlast_b), .busy(busy_b), .done(done_b)
    );

    // register-file contents model
    function automatic logic [31:0] rf(input int unsigned k, input int unsigned mode);
        case (mode)
            0:       return 32'(k) * 32'h0101_0101;
            1:       return 32'(k);
            default: return 32'(k) + 32'd1;
        endcase
    endfunction

    always_comb busa_a = rf(32'(finst_a[25:21]), rf_mode);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            st1_b <= '0;
            st2_b <= '0;
        end else begin
            st1_b <= rf(32'(finst_b[25:21]), rf_mode);
            st2_b <= st1_b;
        end
    end
    assign busa_b = st2_b;

    function automatic void push_range(input int unsigned f, input int unsigned l, input int unsigned mode);
        logic [31:0] x;
        logic        lf;
        x = '0;
        for (int unsigned k = f; k <= l; k++) begin
`ifdef DUMP_CHECKSUM_EN
            lf = 1'b0;
`else
            lf = (k == l);
`endif
            x = x ^ rf(k, mode);
            exp_q.push_back({5'(k), rf(k, mode), lf});
        end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back({5'd0, x, 1'b1});
`endif
    endfunction

    task automatic pulse_start_a(input logic [4:0] f, input logic [4:0] l);
        @(negedge clk);
        start_a = 1; first_a = f; last_a = l;
        @(negedge clk);
        start_a = 0;
    endtask

    task automatic pulse_start_b(input logic [4:0] f, input logic [4:0] l);
        @(negedge clk);
        start_b = 1; first_b = f; last_b = l;
        @(negedge clk);
        start_b = 0;
    endtask

    task automatic test_reset();
        #1 reset = 0;
        #1;
        n_vec++;
        if ({ovr_a, finst_a, valid_a, idx_a, data_a, dlast_a, busy_a, done_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got ovr=%b inst=%h valid=%b idx=%0d data=%h last=%b busy=%b done=%b, required all 0",
                     ovr_a, finst_a, valid_a, idx_a, data_a, dlast_a, busy_a, done_a);
        end
        n_vec++;
        if ({ovr_b, finst_b, valid_b, idx_b, data_b, dlast_b, busy_b, done_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: got ovr=%b inst=%h valid=%b busy=%b done=%b, required all 0",
                     ovr_b, finst_b, valid_b, busy_b, done_b);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1;
    endtask

    // Full 0..31 dump on A with ready high; a stray start mid-run must be ignored.
    task automatic test_full_dump(input int unsigned mode, input string tag);
        int done_t = -1;
        rf_mode = mode;
        exp_q.delete();
        push_range(0, 31, mode);
        ready_a = 1;
        pulse_start_a(5'd0, 5'd31);
        n_vec++;
        if ({ovr_a, finst_a, busy_a} !== {1'b1, 32'h2000_0000, 1'b1}) begin
            n_fail++;
            $display("FAIL %s_first_inst: got ovr=%b inst=%h busy=%b, required ovr=1 inst=20000000 busy=1",
                     tag, ovr_a, finst_a, busy_a);
        end
        for (int t = 0; t < 300; t++) begin
            if (t == 20) begin start_a = 1; first_a = 5'd3; last_a = 5'd4; end
            else start_a = 0;
            if (valid_a && ready_a) begin
                got = {idx_a, data_a, dlast_a};
                last_beat_data = data_a;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_extra_beat: got idx=%0d data=%h, required no beat", tag, idx_a, data_a);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL %s_beat: got idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                                 tag, got.idx, got.data, got.last, exp.idx, exp.data, exp.last);
                    end
                end
            end
            if (done_a) begin done_t = t; break; end
            @(negedge clk);
        end
        start_a = 0;
        n_vec++;
        if (done_t !== 64 + CHK_EXTRA) begin
            n_fail++;
            $display("FAIL %s_done_time: got %0d, required %0d", tag, done_t, 64 + CHK_EXTRA);
        end
        n_vec++;
        if ({ovr_a, busy_a, valid_a} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s_end_state: got ovr=%b busy=%b valid=%b, required 0 0 0", tag, ovr_a, busy_a, valid_a);
        end
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL %s_missing_beats: got %0d left, required 0", tag, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int done_t = -1;
        int stalls = 0;
        rf_mode = 0;
        exp_q.delete();
        push_range(0, 7, 0);
        pulse_start_a(5'd0, 5'd7);
        for (int t = 0; t < 200; t++) begin
            if (valid_a && idx_a == 5'd3 && stalls < 5) begin
                ready_a = 0;
                stalls++;
                n_vec++;
                if ({valid_a, idx_a, data_a, finst_a} !== {1'b1, 5'd3, 32'h0303_0303, 32'h2060_0000}) begin
                    n_fail++;
                    $display("FAIL bp_stall: got valid=%b idx=%0d data=%h inst=%h, required 1 3 03030303 20600000",
                             valid_a, idx_a, data_a, finst_a);
                end
            end else begin
                ready_a = 1;
            end
            if (valid_a && ready_a) begin
                got = {idx_a, data_a, dlast_a};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra_beat: got idx=%0d, required no beat", idx_a);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL bp_beat: got idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                                 got.idx, got.data, got.last, exp.idx, exp.data, exp.last);
                    end
                end
            end
            if (done_a) begin done_t = t; break; end
            @(negedge clk);
        end
        ready_a = 1;
        n_vec++;
        if (done_t !== 21 + CHK_EXTRA || stalls !== 5) begin
            n_fail++;
            $display("FAIL bp_done_time: got t=%0d stalls=%0d, required t=%0d stalls=5", done_t, stalls, 21 + CHK_EXTRA);
        end
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL bp_missing_beats: got %0d left, required 0", exp_q.size());
        end
    endtask

    // Instance B: probe changes two edges after force_inst, DUT samples at three.
    task automatic test_subrange_settle();
        int done_t = -1;
        rf_mode = 0;
        exp_q.delete();
        push_range(5, 7, 0);
        pulse_start_b(5'd5, 5'd7);
        n_vec++;
        if ({ovr_b, finst_b} !== {1'b1, 32'h20A0_0000}) begin
            n_fail++;
            $display("FAIL sub_first_inst: got ovr=%b inst=%h, required ovr=1 inst=20a00000", ovr_b, finst_b);
        end
        for (int t = 0; t < 200; t++) begin
            if (valid_b && ready_b) begin
                got = {idx_b, data_b, dlast_b};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sub_extra_beat: got idx=%0d, required no beat", idx_b);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL sub_beat: got idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                                 got.idx, got.data, got.last, exp.idx, exp.data, exp.last);
                    end
                end
            end
            if (done_b) begin done_t = t; break; end
            @(negedge clk);
        end
        n_vec++;
        if (done_t !== 12 + CHK_EXTRA) begin
            n_fail++;
            $display("FAIL sub_done_time: got %0d, required %0d", done_t, 12 + CHK_EXTRA);
        end
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL sub_missing_beats: got %0d left, required 0", exp_q.size());
        end
    endtask

    task automatic test_empty_range();
        logic [1:0] seen = '0;
        pulse_start_a(5'd9, 5'd4);
        n_vec++;
        if ({done_a, busy_a, ovr_a, valid_a} !== 4'b1000) begin
            n_fail++;
            $display("FAIL empty_pulse: got done=%b busy=%b ovr=%b valid=%b, required 1 0 0 0",
                     done_a, busy_a, ovr_a, valid_a);
        end
        @(negedge clk);
        n_vec++;
        if (done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_done_width: got done=%b, required 0", done_a);
        end
        repeat (4) begin
            seen = seen | {ovr_a, valid_a};
            @(negedge clk);
        end
        n_vec++;
        if (seen !== 2'b00) begin
            n_fail++;
            $display("FAIL empty_no_override: got ovr|valid=%b, required 00", seen);
        end
    endtask

    task automatic test_abort_and_reset();
        logic       aborted = 1'b0;
        logic [2:0] seen = '0;
        int         done_t = -1;
        rf_mode = 0;
        exp_q.delete();
        push_range(0, 31, 0);
        ready_a = 1;
        pulse_start_a(5'd0, 5'd31);
        for (int t = 0; t < 200; t++) begin
            if (valid_a && idx_a == 5'd10) begin abort_a = 1; aborted = 1; break; end
            if (valid_a && ready_a) begin
                got = {idx_a, data_a, dlast_a};
                n_vec++;
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL abort_beat: got idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                             got.idx, got.data, got.last, exp.idx, exp.data, exp.last);
                end
            end
            @(negedge clk);
        end
        n_vec++;
        if (aborted !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reach_idx10: got timeout, required beat idx 10");
        end
        @(negedge clk);
        abort_a = 0;
        n_vec++;
        if ({ovr_a, valid_a, busy_a, done_a} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_idle: got ovr=%b valid=%b busy=%b done=%b, required 0 0 0 0",
                     ovr_a, valid_a, busy_a, done_a);
        end
        repeat (4) begin
            @(negedge clk);
            seen = seen | {done_a, valid_a, ovr_a};
        end
        n_vec++;
        if (seen !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_quiet: got done|valid|ovr=%b, required 000", seen);
        end
        n_vec++;
        if (exp_q.size() !== 22 + CHK_EXTRA) begin
            n_fail++;
            $display("FAIL abort_beats_taken: got %0d left, required %0d", exp_q.size(), 22 + CHK_EXTRA);
        end

        // asynchronous reset in the middle of a fresh dump
        exp_q.delete();
        pulse_start_a(5'd0, 5'd31);
        repeat (6) @(negedge clk);
        n_vec++;
        if ({ovr_a, busy_a} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_pre_busy: got ovr=%b busy=%b, required 1 1", ovr_a, busy_a);
        end
        #1 reset = 0;
        #1;
        n_vec++;
        if ({ovr_a, finst_a, valid_a, idx_a, data_a, dlast_a, busy_a, done_a} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got ovr=%b inst=%h valid=%b idx=%0d data=%h last=%b busy=%b done=%b, required all 0",
                     ovr_a, finst_a, valid_a, idx_a, data_a, dlast_a, busy_a, done_a);
        end
        @(negedge clk);
        reset = 1;

        // normal run afterwards
        push_range(2, 4, 0);
        pulse_start_a(5'd2, 5'd4);
        for (int t = 0; t < 100; t++) begin
            if (valid_a && ready_a) begin
                got = {idx_a, data_a, dlast_a};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rerun_extra_beat: got idx=%0d, required no beat", idx_a);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL rerun_beat: got idx=%0d data=%h last=%b, required idx=%0d data=%h last=%b",
                                 got.idx, got.data, got.last, exp.idx, exp.data, exp.last);
                    end
                end
            end
            if (done_a) begin done_t = t; break; end
            @(negedge clk);
        end
        n_vec++;
        if (done_t !== 6 + CHK_EXTRA || exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL rerun_done: got t=%0d left=%0d, required t=%0d left=0", done_t, exp_q.size(), 6 + CHK_EXTRA);
        end
    endtask

`ifdef DUMP_CHECKSUM_EN
    task automatic test_checksum();
        test_full_dump(1, "ck_k");
        n_vec++;
        if (last_beat_data !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL ck_k_sum: got %h, required 00000000", last_beat_data);
        end
        test_full_dump(2, "ck_k1");
        n_vec++;
        if (last_beat_data !== 32'h0000_0020) begin
            n_fail++;
            $display("FAIL ck_k1_sum: got %h, required 00000020", last_beat_data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_dump(0, "full");
        test_backpressure();
        test_subrange_settle();
        test_empty_range();
        test_abort_and_reset();
`ifdef DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
